// File: rtl/vending_machine_ctrl.sv
// -----------------------------------------------------------------------------
// vending_machine_ctrl
//
// Multi-product vending controller. It sits between the coin acceptor/keypad
// front-end and the dispenser/change-return mechanics. It supports
// runtime-programmable prices, per-product stock counters, a payment timeout
// with auto-refund, customer cancel with full refund, sold-out rejection and
// illegal-coin rejection.
//
// Optional feature: define VEND_STATS_EN to add the vend_count_o and
// revenue_o saturating statistics counters.
//
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous reset, active-high
//   request_i        customer starts a transaction
//   drink_select_i   product index, sampled in SELECT
//   payment_*_i      coin strobes (1/5/10), legal only one at a time in PAY
//   cancel_i         customer abort, refunds everything paid so far
//   price_wr_i       price programming strobe (price_idx_i, price_i)
//   restock_i        restock strobe (restock_idx_i, restock_qty_i)
//   ready_o          high in IDLE
//   start_pay_o      high in PAY
//   drink_o          dispensed product, valid with request_served_o, else 0
//   request_served_o one-cycle dispense pulse
//   changes_o        change (CHANGE) or refund (REFUND) amount, else 0
//   refund_o         one-cycle pulse in REFUND
//   sold_out_o       one-cycle pulse in SOLD_OUT
//   coin_reject_o    registered pulse, the cycle after a rejected coin
//   stock_empty_o    bit i high when product i has no stock
//   state_o          current FSM state, for debug and checkers
//   vend_count_o     (VEND_STATS_EN) number of dispenses, saturating
//   revenue_o        (VEND_STATS_EN) sum of dispensed prices, saturating
//
// Handshake: request_i is accepted only in a cycle where ready_o is high
// (IDLE); request_i in any other cycle is ignored and need not be held.
// -----------------------------------------------------------------------------
module vending_machine_ctrl #(
  parameter int NUM_DRINKS    = 4,
  parameter int MONEY_W       = 6,
  parameter int STOCK_W       = 4,
  parameter int INIT_STOCK    = 3,
  parameter int DEFAULT_PRICE = 10,
  parameter int TIMEOUT_CYC   = 64,
  localparam int SEL_W        = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  request_i,
  input  logic [SEL_W-1:0]      drink_select_i,
  input  logic                  payment_ones_i,
  input  logic                  payment_fives_i,
  input  logic                  payment_tens_i,
  input  logic                  cancel_i,
  input  logic                  price_wr_i,
  input  logic [SEL_W-1:0]      price_idx_i,
  input  logic [MONEY_W-1:0]    price_i,
  input  logic                  restock_i,
  input  logic [SEL_W-1:0]      restock_idx_i,
  input  logic [STOCK_W-1:0]    restock_qty_i,
  output logic                  ready_o,
  output logic                  start_pay_o,
  output logic [SEL_W-1:0]      drink_o,
  output logic                  request_served_o,
  output logic [MONEY_W-1:0]    changes_o,
  output logic                  refund_o,
  output logic                  sold_out_o,
  output logic                  coin_reject_o,
  output logic [NUM_DRINKS-1:0] stock_empty_o,
  output logic [2:0]            state_o
`ifdef VEND_STATS_EN
  ,
  output logic [15:0]           vend_count_o,
  output logic [15:0]           revenue_o
`endif
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_PAY      = 3'd2;
  localparam logic [2:0] ST_CHANGE   = 3'd3;
  localparam logic [2:0] ST_DISPENSE = 3'd4;
  localparam logic [2:0] ST_REFUND   = 3'd5;
  localparam logic [2:0] ST_SOLD_OUT = 3'd6;

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W:0]     NUM_V     = (SEL_W + 1)'(NUM_DRINKS);
  localparam logic [MONEY_W:0]   MONEY_MAX = {1'b0, {MONEY_W{1'b1}}};
  localparam logic [STOCK_W:0]   STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [2:0]         state_q, state_d;
  logic [MONEY_W-1:0] paid_q, paid_d;
  logic [MONEY_W-1:0] price_q, price_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               coin_reject_q, coin_reject_d;

  logic [MONEY_W-1:0] price_tbl_q [NUM_DRINKS];
  logic [STOCK_W-1:0] stock_q     [NUM_DRINKS];
  logic [STOCK_W-1:0] stock_d     [NUM_DRINKS];
  logic [STOCK_W:0]   stock_sum   [NUM_DRINKS];

  // ---------------------------------------------------------------------------
  // Coin decode. A coin is accepted only in PAY, only when exactly one strobe
  // is high, and only if the new total still fits in MONEY_W bits. Every
  // other strobe activity is a rejected coin.
  // ---------------------------------------------------------------------------
  logic [1:0]         n_strobes;
  logic [MONEY_W:0]   coin_val;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_accept;
  logic [MONEY_W-1:0] paid_nxt;

  assign n_strobes = {1'b0, payment_ones_i} + {1'b0, payment_fives_i}
                   + {1'b0, payment_tens_i};

  always_comb begin
    coin_val = '0;
    if (payment_ones_i)       coin_val = (MONEY_W + 1)'(1);
    else if (payment_fives_i) coin_val = (MONEY_W + 1)'(5);
    else if (payment_tens_i)  coin_val = (MONEY_W + 1)'(10);
  end

  assign coin_sum      = {1'b0, paid_q} + coin_val;
  assign coin_accept   = (state_q == ST_PAY) && (n_strobes == 2'd1)
                      && (coin_sum <= MONEY_MAX);
  assign coin_reject_d = (n_strobes != 2'd0) && !coin_accept;
  assign paid_nxt      = coin_accept ? coin_sum[MONEY_W-1:0] : paid_q;

  // Selection lookup; an out-of-range index behaves like an empty product.
  logic               sel_in_range;
  logic [STOCK_W-1:0] sel_stock;
  logic [MONEY_W-1:0] sel_price;

  assign sel_in_range = ({1'b0, drink_select_i} < NUM_V);
  assign sel_stock    = sel_in_range ? stock_q[drink_select_i] : '0;
  assign sel_price    = sel_in_range ? price_tbl_q[drink_select_i] : '0;

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    paid_d  = paid_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    price_d = price_q;
    case (state_q)
      ST_IDLE: begin
        if (request_i) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_stock == '0) begin
          state_d = ST_SOLD_OUT;
        end else begin
          sel_d   = drink_select_i;
          price_d = sel_price;
          state_d = (sel_price == '0) ? ST_DISPENSE : ST_PAY;
        end
      end
      ST_PAY: begin
        // Exit decisions use the total including this cycle's coin, so a coin
        // arriving together with cancel_i is refunded too.
        paid_d  = paid_nxt;
        timer_d = coin_accept ? '0 : timer_q + TMR_W'(1);
        if (cancel_i)                            state_d = ST_REFUND;
        else if (paid_nxt > price_q)             state_d = ST_CHANGE;
        else if (paid_nxt == price_q)            state_d = ST_DISPENSE;
        else if (!coin_accept && timer_q == TMR_LAST) state_d = ST_REFUND;
      end
      ST_CHANGE:   state_d = ST_DISPENSE;
      ST_DISPENSE: state_d = ST_IDLE;
      ST_REFUND:   state_d = ST_IDLE;
      ST_SOLD_OUT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Every path back to IDLE starts the next customer from zero.
    if (state_d == ST_IDLE) begin
      paid_d  = '0;
      timer_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stock update. A dispense and a restock of the same product in the same
  // cycle combine into one saturating update. Stock is non-zero whenever a
  // dispense happens (checked in SELECT), so the decrement cannot wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_DRINKS; i++) begin
      stock_sum[i] = {1'b0, stock_q[i]};
      if (state_q == ST_DISPENSE && sel_q == SEL_W'(i))
        stock_sum[i] = stock_sum[i] - (STOCK_W + 1)'(1);
      if (restock_i && restock_idx_i == SEL_W'(i))
        stock_sum[i] = stock_sum[i] + {1'b0, restock_qty_i};
      stock_d[i] = (stock_sum[i] > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0]
                                              : stock_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      paid_q        <= '0;
      price_q       <= '0;
      sel_q         <= '0;
      timer_q       <= '0;
      coin_reject_q <= 1'b0;
      for (int i = 0; i < NUM_DRINKS; i++) begin
        price_tbl_q[i] <= MONEY_W'(DEFAULT_PRICE);
        stock_q[i]     <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q       <= state_d;
      paid_q        <= paid_d;
      price_q       <= price_d;
      sel_q         <= sel_d;
      timer_q       <= timer_d;
      coin_reject_q <= coin_reject_d;
      // An active transaction keeps its latched price_q; only the table moves.
      if (price_wr_i && ({1'b0, price_idx_i} < NUM_V))
        price_tbl_q[price_idx_i] <= price_i;
      for (int i = 0; i < NUM_DRINKS; i++)
        stock_q[i] <= stock_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from state and registers only
  // ---------------------------------------------------------------------------
  assign ready_o          = (state_q == ST_IDLE);
  assign start_pay_o      = (state_q == ST_PAY);
  assign request_served_o = (state_q == ST_DISPENSE);
  assign refund_o         = (state_q == ST_REFUND);
  assign sold_out_o       = (state_q == ST_SOLD_OUT);
  assign drink_o          = (state_q == ST_DISPENSE) ? sel_q : '0;
  assign coin_reject_o    = coin_reject_q;
  assign state_o          = state_q;

  always_comb begin
    changes_o = '0;
    if (state_q == ST_CHANGE)      changes_o = paid_q - price_q;
    else if (state_q == ST_REFUND) changes_o = paid_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_DRINKS; i++)
      stock_empty_o[i] = (stock_q[i] == '0);
  end

`ifdef VEND_STATS_EN
  logic [15:0] vend_cnt_q;
  logic [15:0] revenue_q;
  logic [16:0] rev_sum;

  assign rev_sum = {1'b0, revenue_q} + 17'(price_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vend_cnt_q <= '0;
      revenue_q  <= '0;
    end else if (state_q == ST_DISPENSE) begin
      if (vend_cnt_q != 16'hFFFF) vend_cnt_q <= vend_cnt_q + 16'd1;
      revenue_q <= rev_sum[16] ? 16'hFFFF : rev_sum[15:0];
    end
  end

  assign vend_count_o = vend_cnt_q;
  assign revenue_o    = revenue_q;
`endif

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_ctrl
//
// Self-checking bench for vending_machine_ctrl (default parameters). The
// reference model works per transaction: it tracks prices, stock and money
// paid as plain integers and pushes the expected output events (change,
// dispense, refund, sold-out) into exp_q; a monitor pops and compares them as
// the DUT produces them. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_vending_machine_ctrl;

  localparam int ND        = 4;
  localparam int SELW      = 2;
  localparam int MW        = 6;
  localparam int SW        = 4;
  localparam int TO        = 64;
  localparam int MONEY_MAX = 63;
  localparam int STOCK_MAX = 15;
  localparam int EW        = 2 + SELW + MW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic            request_i;
  logic [SELW-1:0] drink_select_i;
  logic            payment_ones_i, payment_fives_i, payment_tens_i;
  logic            cancel_i;
  logic            price_wr_i;
  logic [SELW-1:0] price_idx_i;
  logic [MW-1:0]   price_i;
  logic            restock_i;
  logic [SELW-1:0] restock_idx_i;
  logic [SW-1:0]   restock_qty_i;
  logic            ready_o, start_pay_o, request_served_o;
  logic [SELW-1:0] drink_o;
  logic [MW-1:0]   changes_o;
  logic            refund_o, sold_out_o, coin_reject_o;
  logic [ND-1:0]   stock_empty_o;
  logic [2:0]      state_o;
`ifdef VEND_STATS_EN
  logic [15:0]     vend_count_o, revenue_o;
`endif

  vending_machine_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .request_i        (request_i),
    .drink_select_i   (drink_select_i),
    .payment_ones_i   (payment_ones_i),
    .payment_fives_i  (payment_fives_i),
    .payment_tens_i   (payment_tens_i),
    .cancel_i         (cancel_i),
    .price_wr_i       (price_wr_i),
    .price_idx_i      (price_idx_i),
    .price_i          (price_i),
    .restock_i        (restock_i),
    .restock_idx_i    (restock_idx_i),
    .restock_qty_i    (restock_qty_i),
    .ready_o          (ready_o),
    .start_pay_o      (start_pay_o),
    .drink_o          (drink_o),
    .request_served_o (request_served_o),
    .changes_o        (changes_o),
    .refund_o         (refund_o),
    .sold_out_o       (sold_out_o),
    .coin_reject_o    (coin_reject_o),
    .stock_empty_o    (stock_empty_o),
    .state_o          (state_o)
`ifdef VEND_STATS_EN
    ,
    .vend_count_o     (vend_count_o),
    .revenue_o        (revenue_o)
`endif
  );

  // ---------------- reference model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int price_m [ND];
  int stock_m [ND];
  int vend_m, rev_m;
  logic [EW-1:0] exp_q[$];   // {kind, drink, amount}: 0 change, 1 dispense, 2 refund, 3 sold-out
  int act_q[$];              // per-PAY-cycle action: 0 idle, 1/5/10 coin, 2 ones+tens, 3 all three
  int rs_qty, rs_sel;        // restock to issue during the DISPENSE cycle
  bit pw_mid;                // rewrite the price of the active product in its first PAY cycle
  int pw_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void exp_push(input int kind, input int drink, input int amt);
    exp_q.push_back({2'(kind), SELW'(drink), MW'(amt)});
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      price_m[i] = 10;
      stock_m[i] = 3;
    end
    vend_m = 0;
    rev_m  = 0;
  endfunction

  function automatic void dispensed(input int sel, input int price);
    exp_push(1, sel, 0);
    stock_m[sel]--;
    vend_m = (vend_m == 65535) ? 65535 : vend_m + 1;
    rev_m  = (rev_m + price > 65535) ? 65535 : rev_m + price;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] ev;
    logic [EW-1:0] exp_ev;
    bit has;
    has = 0;
    ev  = '0;
    if (!rst_i) begin
      if (sold_out_o)             begin ev = {2'd3, drink_o, changes_o}; has = 1; end
      else if (refund_o)          begin ev = {2'd2, drink_o, changes_o}; has = 1; end
      else if (request_served_o)  begin ev = {2'd1, drink_o, changes_o}; has = 1; end
      else if (changes_o != '0)   begin ev = {2'd0, drink_o, changes_o}; has = 1; end
      if (has) begin
        if (exp_q.size() == 0) begin
          check_eq("event_unexpected", exp_q.size(), 1);
        end else begin
          exp_ev = exp_q.pop_front();
          check_eq("event", ev, exp_ev);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      if (request_served_o && rs_qty > 0) begin
        restock_i     = 1'b1;
        restock_idx_i = SELW'(rs_sel);
        restock_qty_i = SW'(rs_qty);
        stock_m[rs_sel] = (stock_m[rs_sel] + rs_qty > STOCK_MAX) ? STOCK_MAX
                                                                 : stock_m[rs_sel] + rs_qty;
        rs_qty = 0;
      end
      @(negedge clk);
      restock_i = 1'b0;
      n++;
    end
    check_eq("return_to_idle", ready_o, 1);
    rs_qty = 0;
  endtask

  task automatic check_status();
    logic [ND-1:0] exp_empty;
    for (int i = 0; i < ND; i++) exp_empty[i] = (stock_m[i] == 0);
    check_eq("stock_empty", stock_empty_o, exp_empty);
`ifdef VEND_STATS_EN
    check_eq("vend_count", vend_count_o, vend_m);
    check_eq("revenue", revenue_o, rev_m);
`endif
  endtask

  task automatic write_price(input int idx, input int val);
    @(negedge clk);
    price_wr_i = 1'b1; price_idx_i = SELW'(idx); price_i = MW'(val);
    @(negedge clk);
    price_wr_i = 1'b0;
    price_m[idx] = val;
  endtask

  task automatic restock(input int idx, input int qty);
    @(negedge clk);
    restock_i = 1'b1; restock_idx_i = SELW'(idx); restock_qty_i = SW'(qty);
    @(negedge clk);
    restock_i = 1'b0;
    stock_m[idx] = (stock_m[idx] + qty > STOCK_MAX) ? STOCK_MAX : stock_m[idx] + qty;
  endtask

  // One customer transaction driven from act_q; cancel_at < 0 means no cancel.
  task automatic txn(input int sel, input int cancel_at);
    int price, paid, idle, a;
    bit done, acc, rej;
    @(negedge clk);
    check_eq("ready_before_request", ready_o, 1);
    request_i = 1'b1; drink_select_i = SELW'(sel);
    @(negedge clk);
    request_i = 1'b0;
    price  = price_m[sel];
    rs_sel = sel;
    if (stock_m[sel] == 0) begin
      exp_push(3, 0, 0);
      @(negedge clk);
    end else if (price == 0) begin
      dispensed(sel, 0);
      @(negedge clk);
    end else begin
      @(negedge clk);
      check_eq("start_pay", start_pay_o, 1);
      paid = 0; idle = 0; done = 0;
      for (int i = 0; !done && i < 300; i++) begin
        a = (i < act_q.size()) ? act_q[i] : 0;
        payment_ones_i  = (a == 1) || (a == 2) || (a == 3);
        payment_fives_i = (a == 5) || (a == 3);
        payment_tens_i  = (a == 10) || (a == 2) || (a == 3);
        cancel_i        = (i == cancel_at);
        if (i == 0 && pw_mid) begin
          price_wr_i = 1'b1; price_idx_i = SELW'(sel); price_i = MW'(pw_val);
          price_m[sel] = pw_val;
        end
        acc = 0;
        rej = (a == 2) || (a == 3);
        if (a == 1 || a == 5 || a == 10) begin
          if (paid + a <= MONEY_MAX) begin paid += a; acc = 1; end
          else rej = 1;
        end
        if (i == cancel_at) begin
          exp_push(2, 0, paid); done = 1;
        end else if (paid > price) begin
          exp_push(0, 0, paid - price); dispensed(sel, price); done = 1;
        end else if (paid == price) begin
          dispensed(sel, price); done = 1;
        end else if (!acc && idle + 1 == TO) begin
          exp_push(2, 0, paid); done = 1;
        end
        idle = acc ? 0 : idle + 1;
        @(negedge clk);
        payment_ones_i = 1'b0; payment_fives_i = 1'b0; payment_tens_i = 1'b0;
        cancel_i = 1'b0; price_wr_i = 1'b0;
        check_eq("coin_reject", coin_reject_o, rej);
      end
      check_eq("pay_finished", done, 1);
    end
    pw_mid = 0;
    wait_idle();
    check_status();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sel, n, r, cancel_at;
    rst_i = 1'b1; request_i = 1'b0; drink_select_i = '0;
    payment_ones_i = 1'b0; payment_fives_i = 1'b0; payment_tens_i = 1'b0;
    cancel_i = 1'b0; price_wr_i = 1'b0; price_idx_i = '0; price_i = '0;
    restock_i = 1'b0; restock_idx_i = '0; restock_qty_i = '0;
    rs_qty = 0; rs_sel = 0; pw_mid = 0; pw_val = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_start_pay", start_pay_o, 0);
    check_eq("rst_served", request_served_o, 0);
    check_eq("rst_drink", drink_o, 0);
    check_eq("rst_changes", changes_o, 0);
    check_eq("rst_coin_reject", coin_reject_o, 0);
    check_status();
    rst_i = 1'b0;

    // Default price 10, two fives.
    act_q = '{5, 5};                 txn(0, -1);
    // Price 25 with three tens: change of 5.
    write_price(2, 25);
    act_q = '{10, 10, 10};           txn(2, -1);
    // One coin then silence: auto-refund after the timeout.
    act_q = '{5};                    txn(1, -1);
    // Drain product 3, then sold-out, then restock and buy again.
    act_q = '{10};                   txn(3, -1);
    act_q = '{10};                   txn(3, -1);
    act_q = '{10};                   txn(3, -1);
    act_q = '{10};                   txn(3, -1);
    restock(3, 2);
    act_q = '{1, 1, 1, 1, 1, 5};     txn(3, -1);
    // Double strobe rejected, then a five together with cancel.
    act_q = '{2, 5};                 txn(1, 1);
    // Coin strobe in IDLE is rejected and leaves the machine idle.
    @(negedge clk); payment_fives_i = 1'b1;
    @(negedge clk); payment_fives_i = 1'b0;
    check_eq("idle_coin_reject", coin_reject_o, 1);
    check_eq("idle_coin_ready", ready_o, 1);
    // Free product dispenses straight from SELECT.
    write_price(1, 0);
    act_q = '{};                     txn(1, -1);
    // Overflowing coin is rejected at the top of the money range.
    write_price(2, 63);
    act_q = '{10, 10, 10, 10, 10, 10, 10, 1, 1, 1}; txn(2, -1);
    // Price change during payment does not affect the active transaction.
    pw_mid = 1; pw_val = 50;
    act_q = '{5, 5};                 txn(0, -1);
    // Restock in the same cycle as a dispense, and saturation.
    rs_qty = 4;
    act_q = '{10};                   txn(3, -1);
    restock(0, 15);
    check_status();

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0)
        write_price($urandom_range(0, ND - 1),
                    ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MONEY_MAX));
      if ($urandom_range(0, 3) == 0)
        restock($urandom_range(0, ND - 1), $urandom_range(0, STOCK_MAX));
      act_q.delete();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 9);
        case (r)
          0: act_q.push_back(0);
          1: act_q.push_back(2);
          2: act_q.push_back(3);
          3, 4: act_q.push_back(1);
          5, 6: act_q.push_back(5);
          default: act_q.push_back(10);
        endcase
      end
      cancel_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      rs_qty    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, STOCK_MAX) : 0;
      pw_mid    = ($urandom_range(0, 7) == 0);
      pw_val    = $urandom_range(0, MONEY_MAX);
      sel       = $urandom_range(0, ND - 1);
      txn(sel, cancel_at);
    end

    // Reset in the middle of payment discards the money without a refund.
    @(negedge clk);
    request_i = 1'b1; drink_select_i = '0;
    @(negedge clk); request_i = 1'b0;
    @(negedge clk); payment_fives_i = 1'b1;
    @(negedge clk); payment_fives_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", ready_o, 1);
    check_eq("midrst_refund", refund_o, 0);
    check_eq("midrst_changes", changes_o, 0);
    rst_i = 1'b0;
    model_reset();
    check_status();
    act_q = '{5, 5};                 txn(0, -1);

    repeat (5) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
